serial_frame_tx: RTL and testbench

Framed serial transmitter built from registered building blocks. It accepts a parallel word on a valid/ready handshake and shifts it onto a single serial line. The frame is: start bit, data bits, optional even parity, then stop bit(s). Each bit is held for a fixed number of clock cycles. It is the drive-side counterpart to the bit-capture elements in the building-block library, and it serves as the source end for any serial receiver built later.

---
 rtl/serial_frame_pkg.sv | 23 ++
 rtl/serial_frame_tx_bit_tick.sv | 35 +++
 rtl/serial_frame_tx.sv | 137 +++++++++++++
 tb/tb_serial_frame_tx.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the framed serial transmitter.
// Holds the frame state enum, line levels and a frame-length helper.
package serial_frame_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } frame_state_e;

   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;

   // Frame length in bits: start + data + optional parity + stop bits.
   function automatic int frame_len(input int width,
                                    input int parity_en,
                                    input int stop_bits);
      return 1 + width + parity_en + stop_bits;
   endfunction

endpackage

// File: rtl/serial_frame_tx_bit_tick.sv
// bit_tick_counter: counts 0..CLKS_PER_BIT-1 and flags each bit boundary.
// Ports: clk, rst (sync, active-high), clear (hold at 0), tick (last cycle of a bit).
module bit_tick_counter #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // With CLKS_PER_BIT=1 the count stays 0 and every cycle ticks.
   assign tick = (cnt_q == CW'(CLKS_PER_BIT - 1));

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clear || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start, data, optional even parity, stop bit(s).
// Ports: clk, rst, in_data/in_valid/in_ready handshake, tx line, busy, done pulse.
module serial_frame_tx
   import serial_frame_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int LSB_FIRST    = 1,
   parameter int PARITY_EN    = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             tx,
   output logic             busy,
   output logic             done
);

   if (CLKS_PER_BIT < 1 || WIDTH < 1 ||
       (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
      $error("serial_frame_tx: illegal parameter set");
   end

   localparam int BW = $clog2(WIDTH + 2);

   frame_state_e     state_q, state_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic             parity_q, parity_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             tick;
   logic             clear;
   logic             out_bit;

   bit_tick_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clear(clear),
      .tick (tick)
   );

   assign in_ready = (state_q == IDLE);
   assign tx       = tx_q;
   assign busy     = busy_q;
   assign done     = done_q;

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      done_d    = 1'b0;
      clear     = 1'b0;
      unique case (state_q)
         IDLE: begin
            clear = 1'b1;
            if (in_valid) begin
               shift_d   = in_data;
               parity_d  = ^in_data;
               bit_cnt_d = '0;
               state_d   = START;
            end
         end
         START: begin
            if (tick) state_d = DATA;
         end
         DATA: begin
            if (tick) begin
               if (bit_cnt_q == BW'(WIDTH - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
                  shift_d   = (LSB_FIRST != 0) ? (shift_q >> 1)
                                               : (shift_q << 1);
               end
            end
         end
         PARITY: begin
            if (tick) state_d = STOP;
         end
         STOP: begin
            if (tick) begin
               if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = IDLE;
                  done_d    = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // tx is registered, so its next value follows the next state.
   always_comb begin
      out_bit = (LSB_FIRST != 0) ? shift_d[0] : shift_d[WIDTH-1];
      tx_d    = LINE_IDLE;
      unique case (state_d)
         START:   tx_d = LINE_START;
         DATA:    tx_d = out_bit;
         PARITY:  tx_d = parity_d;
         default: tx_d = LINE_IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         parity_q  <= 1'b0;
         tx_q      <= LINE_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         parity_q  <= parity_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed testbench for serial_frame_tx.
// Two instances: 8b/4clk/LSB/parity/1 stop, and 8b/1clk/MSB/no parity/2 stop.
module tb_serial_frame_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready, tx, busy, done;
   logic [7:0] d2;
   logic       v2;
   logic       rdy2, tx2, busy2, done2;

   int total  = 0;
   int passed = 0;
   int fails  = 0;
   int dones;

   always #5 clk = ~clk;

   serial_frame_tx #(
      .WIDTH(8), .CLKS_PER_BIT(4), .LSB_FIRST(1),
      .PARITY_EN(1), .STOP_BITS(1)
   ) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .tx(tx), .busy(busy), .done(done)
   );

   serial_frame_tx #(
      .WIDTH(8), .CLKS_PER_BIT(1), .LSB_FIRST(0),
      .PARITY_EN(0), .STOP_BITS(2)
   ) dut2 (
      .clk(clk), .rst(rst), .in_data(d2), .in_valid(v2),
      .in_ready(rdy2), .tx(tx2), .busy(busy2), .done(done2)
   );

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at the negedge before the accepting edge. Bits are in line
   // order (start first, MSB of vector). nd/nv are applied in cycle 1.
   // Returns at the negedge of the done cycle.
   task automatic watch_frame(input logic [10:0] bits, input logic [7:0] nd,
                              input logic nv, input string tag);
      logic b;
      for (int c = 1; c <= 44; c++) begin
         @(negedge clk);
         b = bits[10 - (c - 1) / 4];
         chk(tag, {4'b0, tx, busy, done, in_ready}, {4'b0, b, 3'b100});
         if (c == 1) begin
            in_data  = nd;
            in_valid = nv;
         end
      end
      @(negedge clk);
      chk({tag, "_done"}, {4'b0, tx, busy, done, in_ready}, 8'h0B);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 8'h11;
      d2 = 8'h00;
      v2 = 1'b0;

      // Reset held 3 cycles with a pending word
      repeat (3) begin
         @(negedge clk);
         chk("rst", {5'b0, tx, busy, done}, 8'h04);
         chk("rst2", {5'b0, tx2, busy2, done2}, 8'h04);
      end
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("post_rst", {4'b0, tx, busy, done, in_ready}, 8'h09);
      chk("post_rst2", {4'b0, tx2, busy2, done2, rdy2}, 8'h09);

      // Single frame 0xA5, parity 0
      in_data = 8'hA5;
      in_valid = 1'b1;
      watch_frame(11'b0_10100101_0_1, 8'hA5, 1'b0, "a5");
      @(negedge clk);
      chk("a5_after", {4'b0, tx, busy, done, in_ready}, 8'h09);

      // Back-to-back 0x00 then 0xFF with valid held
      in_data = 8'h00;
      in_valid = 1'b1;
      watch_frame(11'b0_00000000_0_1, 8'hFF, 1'b1, "b2b00");
      watch_frame(11'b0_11111111_0_1, 8'hFF, 1'b0, "b2bff");
      @(negedge clk);
      chk("b2b_after", {4'b0, tx, busy, done, in_ready}, 8'h09);

      // Data change while busy is ignored; new word follows done
      in_data = 8'h3C;
      in_valid = 1'b1;
      watch_frame(11'b0_00111100_0_1, 8'hFF, 1'b1, "hold3c");
      watch_frame(11'b0_11111111_0_1, 8'hFF, 1'b0, "holdff");
      @(negedge clk);
      chk("hold_after", {4'b0, tx, busy, done, in_ready}, 8'h09);

      // Reset during data bit 3 (cycles 17..20) of 0x3C
      in_data = 8'h3C;
      in_valid = 1'b1;
      for (int c = 1; c <= 17; c++) begin
         @(negedge clk);
         if (c == 1) in_valid = 1'b0;
      end
      chk("mid_bit3", {6'b0, tx, busy}, 8'h03);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort", {4'b0, tx, busy, done, in_ready}, 8'h09);
      dones = 0;
      repeat (50) begin
        @(negedge clk);
        if (done || busy || !tx) dones++;
      end
      chk("abort_quiet", 8'(dones), 8'h00);
      in_data = 8'h55;
      in_valid = 1'b1;
      watch_frame(11'b0_10101010_0_1, 8'h55, 1'b0, "x55");
      @(negedge clk);
      chk("x55_after", {4'b0, tx, busy, done, in_ready}, 8'h09);

      // Variant: 1 clk/bit, MSB first, no parity, 2 stop bits
      begin
         logic [10:0] vb;
         vb = 11'b0_10000001_11;
         d2 = 8'h81;
         v2 = 1'b1;
         for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            chk("v81", {4'b0, tx2, busy2, done2, rdy2},
                {4'b0, vb[11 - c], 3'b100});
            if (c == 1) v2 = 1'b0;
         end
         @(negedge clk);
         chk("v81_done", {4'b0, tx2, busy2, done2, rdy2}, 8'h0B);
         @(negedge clk);
         chk("v81_after", {4'b0, tx2, busy2, done2, rdy2}, 8'h09);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
